// File: rtl/usb_loader_pkg.sv
// rtl/usb_loader_pkg.sv - shared command/response codes and FSM state type for usb_rom_loader
// Contents:
//   CMD_WR / CMD_RD / CMD_PING   host command bytes
//   RSP_ACK / RSP_NAK            single-byte responses
//   state_t                      frame engine states
package usb_loader_pkg;

  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] CMD_PING = 8'h50;

  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_MEM,
    S_RESP
  } state_t;

endpackage

// File: rtl/loader_shreg.sv
// rtl/loader_shreg.sv - 32-bit little-endian word assembler, one byte per load at a 2-bit index
// Ports:
//   i_clk, i_rst   clock, async active-high reset
//   i_clr          clear the whole word (wins over i_load)
//   i_load         write i_byte into byte lane i_idx
//   i_idx          byte lane 0..3 (lane 0 = bits 7:0)
//   i_byte         byte to store
//   o_q            assembled word
module loader_shreg (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_load,
  input  logic [1:0]  i_idx,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_q
);

  logic [31:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q[{i_idx, 3'b000} +: 8] <= i_byte;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/usb_rom_loader.sv
// rtl/usb_rom_loader.sv - FT232H FIFO-side command engine for word write/read/ping frames
// Ports:
//   i_clk, i_rst                       clock, async active-high reset
//   i_rx_empty, o_rx_rd_en, i_rx_dout  RX FIFO (non-FWFT: data valid the cycle after the read strobe)
//   i_tx_full, o_tx_wr_en, o_tx_din    TX FIFO
//   o_mem_req, o_mem_we, o_mem_addr,
//   o_mem_wdata, i_mem_ack, i_mem_rdata  memory port, req held until single-cycle ack
//   o_busy                             high while a frame is in progress
module usb_rom_loader
  import usb_loader_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_empty,
  output logic              o_rx_rd_en,
  input  logic [7:0]        i_rx_dout,
  input  logic              i_tx_full,
  output logic              o_tx_wr_en,
  output logic [7:0]        o_tx_din,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_busy
);

  localparam int                TCNT_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_fetch_pend;
  logic              r_is_wr;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [1:0]        r_idx;
  logic [1:0]        r_rsp_last;
  logic [TCNT_W-1:0] r_tcnt;
  logic [31:0]       r_rsp;

  logic [31:0]       w_addr_q;
  logic [31:0]       w_data_q;
  logic              w_cap;
  logic              w_in_field;
  logic              w_timeout;
  logic              w_tx_acc;
  logic              w_state_chg;
  logic              w_cmd_rw;
  logic              w_shreg_clr;
  logic              w_addr_ld;
  logic              w_data_ld;

  // A read strobe issued last cycle means the FIFO presents its byte now.
  assign w_cap       = r_fetch_pend;
  assign w_in_field  = (r_state == S_ADDR) || (r_state == S_DATA);
  // Expiry is suppressed on a capture cycle, so a byte arriving in time always counts.
  assign w_timeout   = w_in_field && !w_cap && (r_tcnt == TCNT_LAST);
  assign w_tx_acc    = (r_state == S_RESP) && !i_tx_full;
  assign w_cmd_rw    = (i_rx_dout == CMD_WR) || (i_rx_dout == CMD_RD);
  assign w_state_chg = (w_state_next != r_state);

  // Timeout wins over a freshly arrived byte: it stays in the FIFO for the next command.
  // Reset gates the strobe combinationally so it drops the instant rst rises.
  assign o_rx_rd_en  = !i_rst && ((r_state == S_IDLE) || w_in_field) && !i_rx_empty
                       && !r_fetch_pend && !w_timeout;
  assign o_tx_wr_en  = w_tx_acc;
  assign o_tx_din    = (r_state == S_RESP) ? r_rsp[{r_idx, 3'b000} +: 8] : 8'h00;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = w_addr_q[ADDR_W-1:0];
  assign o_mem_wdata = w_data_q;
  assign o_busy      = (r_state != S_IDLE);

  loader_shreg u_addr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_shreg_clr),
    .i_load (w_addr_ld),
    .i_idx  (r_idx),
    .i_byte (i_rx_dout),
    .o_q    (w_addr_q)
  );

  loader_shreg u_wdata (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_shreg_clr),
    .i_load (w_data_ld),
    .i_idx  (r_idx),
    .i_byte (i_rx_dout),
    .o_q    (w_data_q)
  );

  always_comb begin
    w_state_next = r_state;
    w_shreg_clr  = 1'b0;
    w_addr_ld    = 1'b0;
    w_data_ld    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cap) begin
          if (w_cmd_rw) begin
            w_state_next = S_ADDR;
            w_shreg_clr  = 1'b1;
          end else begin
            w_state_next = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (w_timeout) begin
          w_state_next = S_IDLE;
          w_shreg_clr  = 1'b1;
        end else if (w_cap) begin
          w_addr_ld = 1'b1;
          if (r_idx == 2'd3) begin
            w_state_next = r_is_wr ? S_DATA : S_MEM;
          end
        end
      end
      S_DATA: begin
        if (w_timeout) begin
          w_state_next = S_IDLE;
          w_shreg_clr  = 1'b1;
        end else if (w_cap) begin
          w_data_ld = 1'b1;
          if (r_idx == 2'd3) begin
            w_state_next = S_MEM;
          end
        end
      end
      S_MEM: begin
        if (i_mem_ack) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (w_tx_acc && (r_idx == r_rsp_last)) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_fetch_pend <= 1'b0;
      r_is_wr      <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_idx        <= 2'd0;
      r_rsp_last   <= 2'd0;
      r_tcnt       <= '0;
      r_rsp        <= '0;
    end else begin
      r_state      <= w_state_next;
      r_fetch_pend <= o_rx_rd_en;

      // Byte index: shift position while assembling, byte select while responding.
      if (w_state_chg) begin
        r_idx <= 2'd0;
      end else if ((w_in_field && w_cap) || w_tx_acc) begin
        r_idx <= r_idx + 2'd1;
      end

      if (!w_in_field || w_cap || w_state_chg) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= r_tcnt + 1'b1;
      end

      // Ping/NAK responses are known at command capture; W/R overwrite this at ack.
      if ((r_state == S_IDLE) && w_cap) begin
        r_is_wr    <= (i_rx_dout == CMD_WR);
        r_rsp      <= {24'h0, (i_rx_dout == CMD_PING) ? CMD_PING : RSP_NAK};
        r_rsp_last <= 2'd0;
      end

      if ((r_state == S_MEM) && i_mem_ack) begin
        r_rsp      <= r_is_wr ? {24'h0, RSP_ACK} : i_mem_rdata;
        r_rsp_last <= r_is_wr ? 2'd0 : 2'd3;
      end

      if ((w_state_next == S_MEM) && (r_state != S_MEM)) begin
        r_mem_req <= 1'b1;
        r_mem_we  <= r_is_wr;
      end else if ((r_state == S_MEM) && i_mem_ack) begin
        r_mem_req <= 1'b0;
      end
    end
  end

endmodule

// File: doc/usb_rom_loader.md
# usb_rom_loader

Byte-stream command engine sitting on the FIFO side of the FT232H USB bridge. It consumes host bytes from the RX FIFO the bridge fills, decodes word read/write/ping frames, and drives a 32-bit memory/ROM port with a req/ack handshake. It pushes response bytes into the TX FIFO that the bridge drains to the host.

## Interface
- `ADDR_W`, 32: memory address width (≤32; host always sends 4 address bytes, upper bits truncated).
- `TIMEOUT_CYC`, 1_000_000: idle cycles allowed between bytes of one frame before abort.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_empty` in 1: RX FIFO empty.
- `rx_rd_en` out 1: RX FIFO read strobe.
- `rx_dout` in 8: RX FIFO data, valid the cycle after `rx_rd_en` (non-FWFT).
- `tx_full` in 1: TX FIFO full.
- `tx_wr_en` out 1: TX FIFO write strobe.
- `tx_din` out 8: TX FIFO write data.
- `mem_req` out 1: memory request, held until `mem_ack`.
- `mem_we` out 1: 1 = write, 0 = read; stable while `mem_req`.
- `mem_addr` out ADDR_W: word address.
- `mem_wdata` out 32: write data.
- `mem_ack` in 1: single-cycle completion; `mem_rdata` valid in the same cycle.
- `mem_rdata` in 32: read data.
- `busy` out 1: high whenever state ≠ S_IDLE.

## Operation
- Frames, all multi-byte fields little-endian:
  - `0x57` 'W': addr[4], data[4]. Response: `0x06`.
  - `0x52` 'R': addr[4]. Response: rdata[4].
  - `0x50` 'P': no fields. Response: `0x50`.
  - Any other command byte: response `0x15` (NAK); no further bytes consumed.
- States:
  - S_IDLE: fetch the command byte.
  - S_ADDR: 4 bytes.
  - S_DATA: 4 bytes, W only.
  - S_MEM: request outstanding.
  - S_RESP: emit 1 or 4 bytes.
  - Return to S_IDLE after the last response byte.
- Byte fetch:
  - `rx_rd_en` = fetching state & ~rx_empty & no fetch outstanding.
  - Byte captured the following cycle, so the peak rate is 1 byte per 2 cycles.
  - A 2-bit byte index selects the shift position.
  - The index clears on every state entry.
- Memory phase:
  - `mem_req`/`mem_we`/`mem_addr`/`mem_wdata` are registered.
  - They are held constant until the `mem_ack` cycle.
  - `mem_req` drops the cycle after ack.
  - No timeout applies in S_MEM.
- Response:
  - `tx_wr_en` = S_RESP & ~tx_full.
  - `tx_din` is stable while stalled.
  - The index advances only on accepted writes.
- Timeout:
  - Counter width is $clog2(TIMEOUT_CYC)+1.
  - Counts in S_ADDR/S_DATA while no byte is captured, and clears on capture.
  - On reaching TIMEOUT_CYC-1: abort to S_IDLE, no response, partial fields discarded.
  - Never active in S_IDLE.
- `mem_ack` outside S_MEM is ignored.

## Timing
- Reset values:
  - 0: `rx_rd_en`, `tx_wr_en`, `tx_din`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`.
  - State = S_IDLE; counters = 0.
- Asserting `rst` mid-frame or mid-request:
  - All outputs return to reset values immediately.
  - The outstanding memory access is abandoned.
  - The next command byte starts a fresh frame.
- W latency: last data byte captured at cycle t → `mem_req`=1 at t+1. After `mem_ack` at cycle a, `tx_wr_en` with `0x06` at a+1 if ~tx_full.
- R: the read request issues the cycle after the 4th address byte is captured. Bytes rdata[7:0] to rdata[31:24] follow from a+1, one per non-full cycle.
- P / NAK: response byte appears the cycle after the command byte is captured.
- Simultaneous rx_empty deassert and timeout expiry: timeout wins; the byte stays in the FIFO and is parsed as a new command.

## Structure
- Shared package `usb_loader_pkg` holds:
  - Command constants CMD_WR=8'h57, CMD_RD=8'h52, CMD_PING=8'h50.
  - Response constants RSP_ACK=8'h06, RSP_NAK=8'h15.
  - State enum.
- One natural sub-module, `loader_shreg`: 32-bit byte-indexed assembler (load byte at index, clear). Instantiated twice, for addr and wdata.

## Test plan
- Write: `57 10 00 00 00 EF BE AD DE` → one `mem_req` with we=1, addr=0x10, wdata=0xDEADBEEF. After ack, TX receives `06`.
- Read: `52 10 00 00 00`, mem_rdata=0x12345678 → TX receives `78 56 34 12` in order. Hold tx_full high for 3 cycles mid-response; verify no loss or duplication.
- Ping and unknown: `50` → `50`; `AA` → `15`; the following `50` → `50`.
- Timeout: TIMEOUT_CYC=16, send `57 01`, stall → abort with no mem_req and no TX byte. A subsequent `50` → `50`.
- Reset: assert `rst` while `mem_req`=1 → all outputs 0 immediately. After release, a full W frame completes normally.
- Back-to-back: a W frame followed by an R frame to the same address, with data preloaded in the FIFO → the read returns the written word; rx_rd_en never fires while a fetch is outstanding.
